uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART receiver. Captures each completed byte the receiver presents on its level-held ready/data pair, returns a one-cycle read-enable to clear the receiver's ready flag, and stores the byte in a synchronous FIFO. The host reads the FIFO through a show-ahead pop interface with full, empty, count and sticky overrun status.

## Interface

- WIDTH_DATA, 8, byte width; equals the receiver's data width
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2^DEPTH_LOG2 entries)

- i_clk  input  1  system clock, same clock as the receiver
- i_nrst  input  1  reset, asynchronous, active-low
- i_rx_rdy  input  1  receiver ready, level, held until acknowledged
- i_rx_data  input  WIDTH_DATA  receiver byte, stable while i_rx_rdy is high
- o_rx_re  output  1  one-cycle acknowledge to the receiver's read-enable
- i_rd  input  1  host pop request
- o_data  output  WIDTH_DATA  head-of-FIFO byte (show-ahead)
- o_empty  output  1  FIFO holds 0 entries
- o_full  output  1  FIFO holds DEPTH entries
- o_count  output  DEPTH_LOG2+1  number of stored entries, 0..DEPTH
- o_ovr  output  1  sticky overrun flag
- i_ovr_clr  input  1  clears o_ovr
- i_flush  input  1  synchronous FIFO empty

## Operation

- Reset (asynchronous, i_nrst low): write/read pointers 0, o_count 0, o_empty 1, o_full 0, o_ovr 0, o_rx_re 0, capture FSM in IDLE, o_data all-zero. Storage array is not reset.
- Capture FSM, two states:
  - IDLE: if i_rx_rdy = 1, generate a push of i_rx_data this cycle, register o_rx_re = 1 for the next cycle, go to ACK.
  - ACK: o_rx_re = 0 after its single cycle; stay until i_rx_rdy = 0, then go to IDLE. Any byte is never captured twice: a rdy still high in ACK is ignored.
- Push accepted when not full, or when full and a valid pop occurs the same cycle. Push while full without a pop: byte dropped, pointers unchanged, o_ovr set. The acknowledge is issued regardless, so the receiver always frees.
- Pop: i_rd with o_empty = 0 advances the read pointer; i_rd while empty is ignored (no underflow, count stays 0).
- Simultaneous accepted push and pop: o_count unchanged, both pointers advance.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH; full/empty derived from o_count (o_count == DEPTH / == 0).
- o_data = mem[rd_ptr] when not empty, all-zero when empty.
- o_ovr: set on dropped push; cleared by i_ovr_clr; set wins when both occur the same cycle.
- i_flush: pointers and o_count to 0 next cycle; a push or pop in the same cycle is discarded; o_ovr and capture FSM are unaffected.

## Timing

- i_rx_rdy rises at cycle N (FSM in IDLE): entry written at end of N; o_count/o_empty/o_full reflect it in N+1; o_rx_re high in N+1 only.
- Receiver drops rdy one cycle after o_rx_re; FSM returns to IDLE the cycle after it observes i_rx_rdy = 0. Minimum spacing between captures is 3 cycles, far below one UART frame.
- Pop at cycle M: o_data shows next entry (or zero if now empty) in M+1; o_count decrements in M+1.
- Status outputs are registered or derived from registered state only; no combinational path from i_rd or i_rx_rdy to any output.
- Reset asserted mid-capture: FSM returns to IDLE, o_rx_re deasserts immediately; a receiver byte still pending after reset release is captured normally.

## Test plan

- Reset then idle: after release, o_empty = 1, o_full = 0, o_count = 0, o_ovr = 0, o_data = 0x00, o_rx_re = 0.
- Single byte: hold i_rx_rdy high with 0xA5 until one cycle after o_rx_re -> exactly one o_rx_re pulse, o_count = 1, o_data = 0xA5; pop -> o_empty = 1, o_data = 0x00.
- Fill and overrun (DEPTH = 16): push 0x00..0x0F -> o_full = 1, o_count = 16; push 0x10 -> o_rx_re still pulses, o_ovr = 1, count 16; pop all -> 0x00..0x0F in order, 0x10 absent.
- Full with simultaneous push/pop: full FIFO, capture 0x55 in the same cycle as i_rd -> o_count stays 16, o_ovr stays 0, 0x55 read last.
- Wrap-around: 40 interleaved push/pop pairs with incrementing data -> every byte read back in order, count never exceeds 2.
- Flush and overrun clear: 5 entries, assert i_flush with i_rd -> o_count = 0, o_empty = 1; with o_ovr = 1, i_ovr_clr coincident with a dropped push -> o_ovr remains 1; i_ovr_clr alone -> o_ovr = 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive-side byte capture with show-ahead FIFO
// Acknowledges each level-held receiver byte once and buffers it for host pops.
module uart_rx_fifo #(
  parameter int WIDTH_DATA = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_rx_rdy,
  input  logic [WIDTH_DATA-1:0] i_rx_data,
  output logic                  o_rx_re,
  input  logic                  i_rd,
  output logic [WIDTH_DATA-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_ovr,
  input  logic                  i_ovr_clr,
  input  logic                  i_flush
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic {IDLE, ACK} state_t;

  state_t                 state_q, state_d;
  logic                   push_req;
  logic                   push_ok;
  logic                   pop;
  logic                   drop;
  logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
  logic [WIDTH_DATA-1:0]  mem [DEPTH];

  // A byte is taken only on the IDLE->ACK transition, so a rdy still held in ACK is ignored.
  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_rx_rdy) begin
          push_req = 1'b1;
          state_d  = ACK;
        end
      end
      ACK: begin
        if (!i_rx_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
      o_rx_re <= 1'b0;
    end else begin
      state_q <= state_d;
      o_rx_re <= push_req;
    end
  end

  assign pop     = i_rd && !o_empty;
  assign push_ok = push_req && (!o_full || pop);
  assign drop    = push_req && o_full && !pop;

  always_ff @(posedge i_clk) begin
    if (push_ok && !i_flush) mem[wr_ptr] <= i_rx_data;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else if (i_flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

  // Setting beats clearing so an overrun coincident with a clear is never lost.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst)        o_ovr <= 1'b0;
    else if (drop)      o_ovr <= 1'b1;
    else if (i_ovr_clr) o_ovr <= 1'b0;
  end

  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == COUNT_FULL);
  assign o_data  = o_empty ? '0 : mem[rd_ptr];

endmodule
